spi_ram_loader: RTL and testbench
=================================

Name: spi_ram_loader

Overview:
SPI target (mode 0, MSB first) that gives an external SPI master serial write and read access to a small on-chip register RAM. Each frame carries a read/write bit, an address and a data word. Writes are deserialised into the RAM; reads serialise the addressed word onto miso. A parallel debug read port lets on-chip logic and the bench inspect RAM contents.

Parameters:
ADDR_W, 2, address width; RAM depth = 2**ADDR_W words
DATA_W, 4, data word width
FRAME_W, 1+ADDR_W+DATA_W (derived, localparam), bits per frame

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
sclk  input  1  SPI clock from master, asynchronous to clk; frequency <= clk/8
cs_n  input  1  SPI chip select, active low, asynchronous
mosi  input  1  serial data in, asynchronous
miso  output  1  serial data out (driven, never tristated)
wr_stb  output  1  one-clk pulse when a write commits to RAM
rd_stb  output  1  one-clk pulse when read data is loaded for shift-out
abort_stb  output  1  one-clk pulse when cs_n rises mid-frame
busy  output  1  high while a frame is in progress (state != IDLE)
dbg_addr  input  ADDR_W  debug read address
dbg_q  output  DATA_W  combinational read of mem[dbg_addr]

Behaviour:
- Reset (rst sampled high at clk edge): all RAM words = 0; state = IDLE; miso, wr_stb, rd_stb, abort_stb, busy = 0; shift and bit-count registers = 0. Reset mid-frame discards the frame. Logic then waits for cs_n high before accepting a new frame.
- Input sync: sclk, cs_n and mosi each pass through a 2-flop synchroniser. A third register on sclk and on cs_n provides edge detection. rise = sync & ~prev; fall = ~sync & prev.
- Frame format, MSB first: bit0 = rw (1 = read, 0 = write), then ADDR_W address bits, then DATA_W data bits. mosi is sampled on sclk rise.
- States:
  - IDLE -> CMD on cs_n fall.
  - CMD: on sclk rise, latch rw -> ADDR.
  - ADDR: shift address bits in. On the ADDR_W-th rise -> DATA. If rw = 1, on the same clk: load shift register with mem[addr], pulse rd_stb, miso = shift MSB.
  - DATA:
    - Write: shift mosi in on each rise. On the DATA_W-th rise, write mem[addr], pulse wr_stb -> DONE.
    - Read: on each sclk fall, shift left, miso = new MSB. After DATA_W rises -> DONE.
  - DONE: ignore further sclk edges; miso = 0; -> IDLE on cs_n rise.
- cs_n rise in CMD, ADDR or DATA: pulse abort_stb, no RAM write, -> IDLE, miso = 0.
- miso is 0 in every state except read DATA.
- Latency: wr_stb and the RAM update occur on the same clk edge, 3-4 clk cycles after the final sclk pin rise. Read data is on miso at least 4 clk before the first data-phase sclk rise (guaranteed by sclk <= clk/8).
- A debug read of the address being written returns the old value until the write edge, then the new value.
- cs_n fall and sclk rise detected in the same clk: the cs_n fall takes priority and that sclk rise is ignored (mode 0: sclk is low at select).
- Addresses cover the full range; no out-of-range condition exists.

Decomposition:
- Shared package: state encoding (IDLE, CMD, ADDR, DATA, DONE) as localparams, plus the frame-field offset constants derived from ADDR_W/DATA_W.
- One natural sub-module: spi_in_sync (2-flop synchroniser plus edge detector, instantiated per input, outputs level/rise/fall).
- RAM, FSM and shifters stay in the top module.

Test Plan:
- Write frame rw=0, addr=2, data=4'hA at sclk = clk/8 -> single wr_stb pulse; dbg_addr=2 gives dbg_q=4'hA; other words remain 0.
- After writing addr=1 with 4'h6: read frame rw=1, addr=1 -> rd_stb pulse; master samples miso on rises as 0,1,1,0; miso = 0 after cs_n rises.
- Write addr=3 data=4'h5, then cs_n rises after 2 of 4 data bits -> abort_stb pulse, no wr_stb, mem[3] unchanged (0); next full frame is accepted normally.
- Write frame with 3 extra sclk pulses before cs_n rises -> exactly one wr_stb; extra bits ignored; miso stays 0.
- Assert rst for 1 clk in the middle of a write frame to addr=0 (mem[0] previously 4'hF) -> mem[0]=0, all strobes 0, busy=0. A new frame is accepted only after cs_n goes high then low.
- Back-to-back frames with cs_n high for 4 clk between them (write addr=0 4'h3, then read addr=0) -> read returns 0,0,1,1.

Source files
------------

// File: rtl/spi_ram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_loader_pkg
// Description : Shared FSM encoding and frame-field layout for spi_ram_loader.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_ram_loader_pkg;

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_CMD  = 3'd1;
    localparam logic [2:0] c_S_ADDR = 3'd2;
    localparam logic [2:0] c_S_DATA = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = c_S_IDLE,
        ST_CMD  = c_S_CMD,
        ST_ADDR = c_S_ADDR,
        ST_DATA = c_S_DATA,
        ST_DONE = c_S_DONE
    } state_t;

    // Frame layout, counted from the first bit on the wire
    localparam int unsigned c_RW_POS   = 0;
    localparam int unsigned c_ADDR_POS = 1;

    function automatic int unsigned data_pos(input int unsigned addr_w);
        return c_ADDR_POS + addr_w;
    endfunction

    function automatic int unsigned frame_bits(input int unsigned addr_w,
                                               input int unsigned data_w);
        return data_pos(addr_w) + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ram_loader_spi_in_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_in_sync
// Description : Two-flop synchroniser with optional edge-detect register.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_in_sync #(
    parameter bit EDGE_DET = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
        end
    end

    assign o_level = r_sync;

    generate
        if (EDGE_DET) begin : g_edge
            logic r_prev;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_prev <= 1'b0;
                end else begin
                    r_prev <= r_sync;
                end
            end
            assign o_rise = r_sync & ~r_prev;
            assign o_fall = ~r_sync & r_prev;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
            assign o_fall = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/spi_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_loader
// Description : SPI mode-0 target giving serial read/write access to a small RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_loader
    import spi_ram_loader_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              wr_stb,
    output logic              rd_stb,
    output logic              abort_stb,
    output logic              busy,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_q
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int FRAME_W = int'(frame_bits(ADDR_W, DATA_W));
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0] c_ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] c_DATA_LAST = CNT_W'(DATA_W - 1);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused_levels;

    spi_in_sync #(.EDGE_DET(1'b1)) u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (sclk),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_in_sync #(.EDGE_DET(1'b1)) u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (cs_n),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_in_sync #(.EDGE_DET(1'b0)) u_sync_mosi (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (mosi),
        .o_level (w_mosi),
        .o_rise  (w_mosi_rise),
        .o_fall  (w_mosi_fall)
    );

    assign w_unused_levels = w_sclk_level | w_cs_level | w_mosi_rise | w_mosi_fall;

    state_t             r_state;
    logic               r_rw;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic               r_miso;
    logic               r_wr_stb;
    logic               r_rd_stb;
    logic               r_abort_stb;
    logic               r_busy;

    logic [ADDR_W-1:0]  w_addr_next;
    logic [DATA_W-1:0]  w_shift_next;
    logic [DATA_W-1:0]  w_rd_word;
    logic               w_abort;

    assign w_addr_next  = ADDR_W'({r_addr, w_mosi});
    assign w_shift_next = DATA_W'({r_shift, w_mosi});
    assign w_rd_word    = r_mem[w_addr_next];
    assign w_abort      = w_cs_rise &&
                          (r_state == ST_CMD || r_state == ST_ADDR || r_state == ST_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_miso      <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_rd_stb    <= 1'b0;
            r_abort_stb <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_wr_stb    <= 1'b0;
            r_rd_stb    <= 1'b0;
            r_abort_stb <= 1'b0;
            if (w_abort) begin
                r_abort_stb <= 1'b1;
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_miso      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // A select edge wins over any sclk edge seen in the same cycle
                        if (w_cs_fall) begin
                            r_state <= ST_CMD;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_shift <= '0;
                            r_addr  <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_rw    <= w_mosi;
                            r_cnt   <= '0;
                            r_state <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (w_sclk_rise) begin
                            r_addr <= w_addr_next;
                            if (r_cnt == c_ADDR_LAST) begin
                                r_cnt   <= '0;
                                r_state <= ST_DATA;
                                if (r_rw) begin
                                    r_shift  <= w_rd_word;
                                    r_rd_stb <= 1'b1;
                                    r_miso   <= w_rd_word[DATA_W-1];
                                end
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (r_rw) begin
                            if (w_sclk_rise) begin
                                if (r_cnt == c_DATA_LAST) begin
                                    r_state <= ST_DONE;
                                    r_miso  <= 1'b0;
                                end
                                r_cnt <= r_cnt + 1'b1;
                            // The fall that closes the address phase must not shift: MSB is already out
                            end else if (w_sclk_fall && r_cnt != '0) begin
                                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                                r_miso  <= r_shift[DATA_W-2];
                            end
                        end else if (w_sclk_rise) begin
                            r_shift <= w_shift_next;
                            r_cnt   <= r_cnt + 1'b1;
                            if (r_cnt == c_DATA_LAST) begin
                                r_mem[r_addr] <= w_shift_next;
                                r_wr_stb      <= 1'b1;
                                r_state       <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_miso <= 1'b0;
                        if (w_cs_rise) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_miso  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign miso      = r_miso;
    assign wr_stb    = r_wr_stb;
    assign rd_stb    = r_rd_stb;
    assign abort_stb = r_abort_stb;
    assign busy      = r_busy;
    assign dbg_q     = r_mem[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_ram_loader
// Description : Self-checking bench driving SPI frames against a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_loader;

    localparam int ADDR_W  = 2;
    localparam int DATA_W  = 4;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int HALF    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              cs_n = 1'b1;
    logic              mosi = 1'b0;
    logic              miso;
    logic              wr_stb;
    logic              rd_stb;
    logic              abort_stb;
    logic              busy;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [DATA_W-1:0] dbg_q;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int ab_cnt   = 0;
    int miso_stray = 0;
    int unsigned model [DEPTH];

    spi_ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .wr_stb    (wr_stb),
        .rd_stb    (rd_stb),
        .abort_stb (abort_stb),
        .busy      (busy),
        .dbg_addr  (dbg_addr),
        .dbg_q     (dbg_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_stb)    wr_cnt++;
        if (rd_stb)    rd_cnt++;
        if (abort_stb) ab_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_cnt();
        wr_cnt = 0; rd_cnt = 0; ab_cnt = 0; miso_stray = 0;
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            dbg_addr = ADDR_W'(a);
            #1;
            check($sformatf("%s mem[%0d]", tag, a), 32'(dbg_q), model[a]);
        end
    endtask

    task automatic sclk_bit(input logic b);
        mosi = b;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    // Master side of one frame; nbits may be short (abort) or long (extra clocks)
    task automatic frame(input bit rw, input int unsigned addr, input int unsigned data,
                         input int nbits, input int gap, output int unsigned rd);
        logic [FRAME_W-1:0] f;
        f = {rw, addr[ADDR_W-1:0], data[DATA_W-1:0]};
        rd = 0;
        @(negedge clk) cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < FRAME_W) ? f[FRAME_W-1-i] : 1'b0;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            if (rw && i >= 1 + ADDR_W && i < FRAME_W) rd = (rd << 1) | 32'(miso);
            else if (miso !== 1'b0) miso_stray++;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Runs a frame and checks it against the model: strobes, read data, RAM
    task automatic do_frame(input string tag, input bit rw, input int unsigned addr,
                            input int unsigned data, input int nbits, input int gap);
        int unsigned rd;
        bit full;
        full = (nbits >= FRAME_W);
        clr_cnt();
        frame(rw, addr, data, nbits, gap, rd);
        check({tag, " wr_stb"}, wr_cnt, (full && !rw) ? 1 : 0);
        check({tag, " rd_stb"}, rd_cnt, (rw && nbits >= 1 + ADDR_W) ? 1 : 0);
        check({tag, " abort"},  ab_cnt, full ? 0 : 1);
        check({tag, " stray miso"}, miso_stray, 0);
        if (rw && full) check({tag, " rdata"}, rd, model[addr]);
        if (full && !rw) model[addr] = data;
        check({tag, " miso idle"}, 32'(miso), 0);
        check({tag, " busy idle"}, 32'(busy), 0);
        check_mem(tag);
    endtask

    initial begin
        int unsigned rd;
        for (int a = 0; a < DEPTH; a++) model[a] = 0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reset miso", 32'(miso), 0);
        check("reset wr_stb", 32'(wr_stb), 0);
        check("reset rd_stb", 32'(rd_stb), 0);
        check("reset abort", 32'(abort_stb), 0);
        check("reset busy", 32'(busy), 0);
        check_mem("reset");

        do_frame("wr a2", 1'b0, 2, 4'hA, FRAME_W, 6);
        do_frame("wr a1", 1'b0, 1, 4'h6, FRAME_W, 6);
        do_frame("rd a1", 1'b1, 1, 0, FRAME_W, 6);
        do_frame("abort a3", 1'b0, 3, 4'h5, FRAME_W - 2, 6);
        do_frame("after abort", 1'b0, 3, 4'h9, FRAME_W, 6);
        do_frame("extra clk", 1'b0, 0, 4'hF, FRAME_W + 3, 6);

        // Reset in the middle of a write to addr 0
        clr_cnt();
        @(negedge clk) cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 4; i++) sclk_bit(i[0]);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) model[a] = 0;
        check("mid rst busy", 32'(busy), 0);
        check("mid rst miso", 32'(miso), 0);
        check_mem("mid rst");
        for (int i = 0; i < FRAME_W; i++) sclk_bit(1'b1);
        check("post rst busy", 32'(busy), 0);
        check("post rst strobes", 32'(wr_cnt + rd_cnt + ab_cnt), 0);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);

        do_frame("b2b wr", 1'b0, 0, 4'h3, FRAME_W, 4);
        do_frame("b2b rd", 1'b1, 0, 0, FRAME_W, 6);

        for (int k = 0; k < 12; k++) begin
            do_frame($sformatf("rand%0d", k), 1'($urandom_range(0, 1)),
                     $urandom_range(0, DEPTH - 1), $urandom_range(0, 15),
                     (k % 5 == 4) ? int'($urandom_range(1, FRAME_W - 1)) : FRAME_W, 5);
        end
        for (int a = 0; a < DEPTH; a++) begin
            clr_cnt();
            frame(1'b1, a, 0, FRAME_W, 5, rd);
            check($sformatf("final rd a%0d", a), rd, model[a]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
